// File: rtl/match_vector_reduce_pkg.sv
// Shared constants for the mask vector engine and match reduction stage.
package match_vector_reduce_pkg;

    localparam int KWID   = 104;
    localparam int SEGWID = 10;
    localparam int NVEC   = KWID / 8;
    localparam int VTWID  = SEGWID * NVEC;
    localparam int AWID   = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int IDXW  = clog2(VTWID);
    // Vectors are ANDed in groups of four in the first stage.
    localparam int NPART = (NVEC + 3) / 4;

endpackage

// File: rtl/match_vector_reduce_if.sv
// Input/output bundle of match_vector_reduce; stats counters exist only
// when MATCH_REDUCE_STATS_EN is defined.
interface match_vector_reduce_if;
    import match_vector_reduce_pkg::*;

    logic                             i_Valid;
    logic                             o_In_Ready;
    logic [NVEC-1:0][VTWID-1:0]       i_Mask_Vector;  // element 0 is mask vector 1
    logic                             o_Valid;
    logic                             i_Out_Ready;
    logic                             o_Hit;
    logic [AWID-1:0]                  o_Match_Addr;
    logic [VTWID-1:0]                 o_Match_Vector;
`ifdef MATCH_REDUCE_STATS_EN
    logic [31:0]                      o_Search_Count;
    logic [31:0]                      o_Hit_Count;
`endif

    modport slave (
        input  i_Valid, i_Mask_Vector, i_Out_Ready,
        output o_In_Ready, o_Valid, o_Hit, o_Match_Addr, o_Match_Vector
`ifdef MATCH_REDUCE_STATS_EN
        , output o_Search_Count, o_Hit_Count
`endif
    );

    modport master (
        output i_Valid, i_Mask_Vector, i_Out_Ready,
        input  o_In_Ready, o_Valid, o_Hit, o_Match_Addr, o_Match_Vector
`ifdef MATCH_REDUCE_STATS_EN
        , input o_Search_Count, o_Hit_Count
`endif
    );

endinterface

// File: rtl/match_vector_reduce_prio_enc.sv
// Combinational lowest-set-bit priority encoder for the match vector.
module match_prio_enc
    import match_vector_reduce_pkg::*;
(
    input  logic [VTWID-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             hit
);

    always_comb begin
        idx = '0;
        hit = |vec;
        // Scan downward so the lowest set position is the last one written.
        for (int i = VTWID - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/match_vector_reduce.sv
// Three-stage AND-reduce and priority-encode of the 13 mask vectors.
// Optional MATCH_REDUCE_STATS_EN adds saturating search/hit counters.
module match_vector_reduce
    import match_vector_reduce_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    match_vector_reduce_if.slave bus
);

    logic                         advance;
    logic [NPART-1:0][VTWID-1:0]  and_part;
    logic [VTWID-1:0]             match_all;
    logic [IDXW-1:0]              enc_idx;
    logic                         enc_hit;

    logic                         v1_q, v1_d;
    logic [NPART-1:0][VTWID-1:0]  partial_q, partial_d;
    logic                         v2_q, v2_d;
    logic [VTWID-1:0]             match_q, match_d;
    logic                         valid_q, valid_d;
    logic                         hit_q, hit_d;
    logic [AWID-1:0]              addr_q, addr_d;
    logic [VTWID-1:0]             vec_q, vec_d;

    // A single advance signal moves every stage together, so bubbles are kept.
    always_comb advance = !valid_q || bus.i_Out_Ready;

    genvar gi;
    generate
        for (gi = 0; gi < NPART; gi++) begin : g_part
            localparam int LO = gi * 4;
            localparam int HI = (gi * 4 + 3 < NVEC) ? gi * 4 + 3 : NVEC - 1;
            logic [VTWID-1:0] part;
            always_comb begin
                part = '1;
                for (int v = LO; v <= HI; v++) begin
                    part = part & bus.i_Mask_Vector[v];
                end
            end
            assign and_part[gi] = part;
        end
    endgenerate

    always_comb begin
        match_all = '1;
        for (int p = 0; p < NPART; p++) begin
            match_all = match_all & partial_q[p];
        end
    end

    match_prio_enc u_prio_enc (
        .vec (match_q),
        .idx (enc_idx),
        .hit (enc_hit)
    );

    always_comb begin
        v1_d      = v1_q;
        partial_d = partial_q;
        v2_d      = v2_q;
        match_d   = match_q;
        valid_d   = valid_q;
        hit_d     = hit_q;
        addr_d    = addr_q;
        vec_d     = vec_q;
        if (advance) begin
            v1_d      = bus.i_Valid;
            partial_d = and_part;
            v2_d      = v1_q;
            match_d   = match_all;
            valid_d   = v2_q;
            hit_d     = enc_hit;
            addr_d    = AWID'(enc_idx);
            vec_d     = match_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            partial_q <= '0;
            v2_q      <= 1'b0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            addr_q    <= '0;
            vec_q     <= '0;
        end else begin
            v1_q      <= v1_d;
            partial_q <= partial_d;
            v2_q      <= v2_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            addr_q    <= addr_d;
            vec_q     <= vec_d;
        end
    end

    assign bus.o_In_Ready     = advance;
    assign bus.o_Valid        = valid_q;
    assign bus.o_Hit          = hit_q;
    assign bus.o_Match_Addr   = addr_q;
    assign bus.o_Match_Vector = vec_q;

`ifdef MATCH_REDUCE_STATS_EN
    logic        handshake;
    logic [31:0] search_cnt_q, search_cnt_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        handshake    = valid_q && bus.i_Out_Ready;
        search_cnt_d = search_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (handshake && (search_cnt_q != 32'hFFFF_FFFF)) begin
            search_cnt_d = search_cnt_q + 32'd1;
        end
        if (handshake && hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            search_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            search_cnt_q <= search_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign bus.o_Search_Count = search_cnt_q;
    assign bus.o_Hit_Count    = hit_cnt_q;
`endif

endmodule
